// File: rtl/prio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prio_pkg
//  Description : Shared constants for the priority arbiter: FSM state
//                encoding and the arbitration-mode selector values.
//  Revision    : 1.0 - initial release
// ============================================================================
package prio_pkg;

    // FSM state encoding (explicit 1-bit width)
    localparam logic [0:0] IDLE  = 1'b0;   // no channel granted
    localparam logic [0:0] GRANT = 1'b1;   // exactly one channel granted

    // Arbitration mode selector
    localparam int MODE_FIXED = 0;         // highest asserted index wins
    localparam int MODE_RR    = 1;         // rotate downward from last grant

endpackage
`default_nettype wire

// File: rtl/prio_enc.sv
`default_nettype none
// ============================================================================
//  Module      : prio_enc
//  Description : Combinational wrap-around priority encoder. Scans the
//                request vector downward starting at 'start', wrapping from
//                index 0 to N-1, and reports the first asserted position.
//  Ports       : req   - request vector to search
//                start - first index examined
//                idx   - winning index (0 when nothing found)
//                found - high when any request bit is set
//  Revision    : 1.0 - initial release
// ============================================================================
module prio_enc #(
    parameter int N    = 4,
    parameter int IDXW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] start,
    output logic [IDXW-1:0] idx,
    output logic            found
);

    // Position examined at step k of the scan: start, start-1, ... modulo N.
    function automatic logic [IDXW-1:0] f_pos(input logic [IDXW-1:0] s, input int k);
        int p;
        p = int'(s) - k;
        if (p < 0) begin
            p = p + N;
        end
        return p[IDXW-1:0];
    endfunction

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[f_pos(start, k)]) begin
                found = 1'b1;
                idx   = f_pos(start, k);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/prio_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : prio_arbiter
//  Description : N-channel request arbiter with fixed-priority or
//                round-robin selection and a bounded hold time. All outputs
//                are registered; requests never reach them combinationally.
//  Ports       : clk     - clock, rising edge
//                rst_n   - asynchronous active-low reset
//                req     - level request per channel
//                gnt     - one-hot grant
//                gnt_idx - binary index of the granted channel (0 when idle)
//                valid   - high while a grant is active
//  Revision    : 1.0 - initial release
// ============================================================================
module prio_arbiter
    import prio_pkg::*;
#(
    parameter int N        = 4,
    parameter int MODE     = 0,
    parameter int MAX_HOLD = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [N-1:0]                        req,
    output logic [N-1:0]                        gnt,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] gnt_idx,
    output logic                                valid
);

    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    localparam logic [7:0]      c_hold_max = 8'(MAX_HOLD - 1);
    localparam logic [IDXW-1:0] c_top_idx  = IDXW'(N - 1);
    localparam logic [N-1:0]    c_one      = N'(1);

    // Registered state
    logic [0:0]      r_state;
    logic [IDXW-1:0] r_idx;
    logic [7:0]      r_hold;
    logic [IDXW-1:0] r_last;
    logic [N-1:0]    r_gnt;
    logic            r_valid;

    // Next-state values
    logic [0:0]      w_state_nxt;
    logic [IDXW-1:0] w_idx_nxt;
    logic [7:0]      w_hold_nxt;
    logic [IDXW-1:0] w_last_nxt;
    logic [N-1:0]    w_gnt_nxt;
    logic            w_valid_nxt;

    // Arbitration datapath
    logic [N-1:0]    w_others;
    logic [N-1:0]    w_enc_req;
    logic [IDXW-1:0] w_start;
    logic [IDXW-1:0] w_win_idx;
    logic            w_win_found;
    logic            w_cur;
    logic            w_at_limit;

    assign w_cur      = req[r_idx];
    assign w_others   = req & ~r_gnt;
    assign w_at_limit = (r_hold == c_hold_max);

    // While granting, the current holder is excluded so a forced hand-off
    // can never re-select it; when idle the full vector competes.
    assign w_enc_req = (r_state == GRANT) ? w_others : req;

    // Round-robin scans from the channel just below the last winner, so the
    // last winner itself is examined last. After reset last=0, which makes
    // the scan start at N-1 just like fixed priority.
    assign w_start = (MODE == MODE_RR && r_last != '0) ? (r_last - 1'b1) : c_top_idx;

    prio_enc #(
        .N    (N),
        .IDXW (IDXW)
    ) u_enc (
        .req   (w_enc_req),
        .start (w_start),
        .idx   (w_win_idx),
        .found (w_win_found)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_hold  <= '0;
            r_last  <= '0;
            r_gnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_hold  <= w_hold_nxt;
            r_last  <= w_last_nxt;
            r_gnt   <= w_gnt_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_hold_nxt  = r_hold;
        w_last_nxt  = r_last;
        case (r_state)
            IDLE: begin
                if (w_win_found) begin
                    w_state_nxt = GRANT;
                    w_idx_nxt   = w_win_idx;
                    w_hold_nxt  = '0;
                    w_last_nxt  = w_win_idx;
                end else begin
                    w_idx_nxt   = '0;
                    w_hold_nxt  = '0;
                end
            end
            GRANT: begin
                // Keep the holder unless it released or its time is up
                // while someone else is waiting.
                if (w_cur && !(w_at_limit && (|w_others))) begin
                    w_hold_nxt = w_at_limit ? r_hold : (r_hold + 8'd1);
                end else if (w_win_found) begin
                    w_idx_nxt  = w_win_idx;
                    w_hold_nxt = '0;
                    w_last_nxt = w_win_idx;
                end else begin
                    w_state_nxt = IDLE;
                    w_idx_nxt   = '0;
                    w_hold_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = '0;
                w_hold_nxt  = '0;
            end
        endcase
    end

    // ---------------- output decode (registered above) ----------------
    always_comb begin
        w_gnt_nxt   = '0;
        w_valid_nxt = 1'b0;
        if (w_state_nxt == GRANT) begin
            w_gnt_nxt   = c_one << w_idx_nxt;
            w_valid_nxt = 1'b1;
        end
    end

    assign gnt     = r_gnt;
    assign gnt_idx = r_idx;
    assign valid   = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_prio_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prio_arbiter
//  Description : Self-checking bench for prio_arbiter. Runs a fixed-priority
//                and a round-robin instance side by side on shared stimulus,
//                compares both against a cycle-level behavioural model, and
//                pins the model with hand-computed scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prio_arbiter;

    localparam int NCH  = 4;
    localparam int HOLD = 4;

    logic             clk;
    logic             rst_n;
    logic [NCH-1:0]   req;
    logic [NCH-1:0]   gnt0, gnt1;
    logic [1:0]       idx0, idx1;
    logic             valid0, valid1;

    int n_checks = 0;
    int n_fail   = 0;

    prio_arbiter #(.N(NCH), .MODE(0), .MAX_HOLD(HOLD)) u_dut_fixed (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt0), .gnt_idx(idx0), .valid(valid0)
    );

    prio_arbiter #(.N(NCH), .MODE(1), .MAX_HOLD(HOLD)) u_dut_rr (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt1), .gnt_idx(idx1), .valid(valid1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: v = granting, idx = holder, age = cycles the
    // holder has owned the grant so far, last = most recent winner.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic v;
        int   idx;
        int   age;
        int   last;
    } mstate_t;

    mstate_t m [2];

    function automatic int pick(input logic [NCH-1:0] c, input int mode, input int last);
        int w;
        w = -1;
        if (mode == 0) begin
            for (int i = 0; i < NCH; i++) if (c[i]) w = i;
        end else begin
            // order of preference: last-1, last-2, ... wrapping, last itself final
            for (int k = NCH; k >= 1; k--) if (c[(last - k + NCH) % NCH]) w = (last - k + NCH) % NCH;
        end
        return w;
    endfunction

    function automatic mstate_t model_next(input mstate_t s, input logic [NCH-1:0] r, input int mode);
        mstate_t          n;
        logic [NCH-1:0]   others;
        logic [NCH-1:0]   cand;
        others = r;
        if (s.v) others[s.idx] = 1'b0;
        if (s.v && r[s.idx] && (s.age < HOLD || others == '0)) begin
            n = s;
            if (s.age < 1000) n.age = s.age + 1;
        end else begin
            cand = s.v ? others : r;
            if (cand == '0) begin
                n.v = 1'b0; n.idx = 0; n.age = 0; n.last = s.last;
            end else begin
                n.v = 1'b1; n.idx = pick(cand, mode, s.last); n.age = 1; n.last = n.idx;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m[0] <= '0;
            m[1] <= '0;
        end else begin
            m[0] <= model_next(m[0], req, 0);
            m[1] <= model_next(m[1], req, 1);
        end
    end

    task automatic compare_one(input string tag, input mstate_t s, input logic [NCH-1:0] g,
                               input logic [1:0] gi, input logic v);
        logic [NCH-1:0] e;
        logic           consistent;
        e = '0;
        if (s.v) e[s.idx] = 1'b1;
        check({tag, " gnt"},     32'(g),  32'(e));
        check({tag, " gnt_idx"}, 32'(gi), s.v ? 32'(s.idx) : 32'd0);
        check({tag, " valid"},   32'(v),  32'(s.v));
        check({tag, " onehot0"}, 32'($onehot0(g)), 32'd1);
        consistent = v ? (g == (4'b0001 << gi)) : (g == '0 && gi == '0);
        check({tag, " idx/gnt consistency"}, 32'(consistent), 32'd1);
    endtask

    always @(negedge clk) begin
        compare_one("fixed", m[0], gnt0, idx0, valid0);
        compare_one("rr",    m[1], gnt1, idx1, valid1);
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int exp_rot [5] = '{3, 2, 1, 0, 3};

    initial begin
        rst_n = 1'b0;
        req   = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // idle after reset
        repeat (5) begin
            @(negedge clk);
            check("idle gnt fixed",   32'(gnt0),   32'd0);
            check("idle valid fixed", 32'(valid0), 32'd0);
            check("idle gnt rr",      32'(gnt1),   32'd0);
            check("idle valid rr",    32'(valid1), 32'd0);
        end

        // fixed priority pick and hand-off on release
        do_reset();
        req = 4'b0110;
        @(negedge clk);
        check("fp first gnt",   32'(gnt0),   32'h4);
        check("fp first idx",   32'(idx0),   32'd2);
        check("fp first valid", 32'(valid0), 32'd1);
        req = 4'b0010;
        @(negedge clk);
        check("fp handoff gnt", 32'(gnt1 & 4'b0) | 32'(gnt0), 32'h2);
        check("fp handoff idx", 32'(idx0), 32'd1);

        // round-robin rotation under hold limit
        do_reset();
        req = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("rr rotation idx",   32'(idx1),   32'(exp_rot[c / 4]));
            check("rr rotation valid", 32'(valid1), 32'd1);
        end

        // lone requester keeps grant past the limit, yields once contended
        do_reset();
        req = 4'b1000;
        repeat (10) begin
            @(negedge clk);
            check("lone hold gnt", 32'(gnt0), 32'h8);
        end
        req = 4'b1001;
        @(negedge clk);
        check("forced switch gnt", 32'(gnt0), 32'h1);

        // asynchronous reset mid-grant
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst gnt fixed",   32'(gnt0),   32'd0);
        check("async rst valid fixed", 32'(valid0), 32'd0);
        check("async rst gnt rr",      32'(gnt1),   32'd0);
        check("async rst valid rr",    32'(valid1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b0011;
        @(negedge clk);
        check("post rst gnt fixed", 32'(gnt0), 32'h2);
        check("post rst gnt rr",    32'(gnt1), 32'h2);

        // randomized traffic with occasional mid-cycle resets
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            case ($urandom_range(0, 7))
                0, 1:    req = 4'($urandom_range(0, 15));
                2:       req[$urandom_range(0, 3)] = ~req[$urandom_range(0, 3)];
                default: req = req;
            endcase
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prio_arbiter.md
PRIO_ARBITER -- requirements
Module: prio_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 4, number of request channels, legal range 2..32.
REQ-002 The block SHALL have parameter MODE, default 0: 0 = fixed priority (highest index wins), 1 = round-robin.
REQ-003 The block SHALL have parameter MAX_HOLD, default 8, maximum grant cycles while other requests wait, legal range 1..255.
REQ-004 The block SHALL derive localparam IDXW = max(1, clog2(N)).
REQ-005 Port clk, input, 1: single clock, all state on rising edge.
REQ-006 Port rst_n, input, 1: asynchronous active-low reset.
REQ-007 Port req, input, N: level request per channel, held high until service complete.
REQ-008 Port gnt, output, N: registered one-hot grant.
REQ-009 Port gnt_idx, output, IDXW: registered binary index of the granted channel.
REQ-010 Port valid, output, 1: registered, high when gnt is non-zero.

Function
REQ-011 The FSM SHALL have two states, IDLE (no grant) and GRANT (one channel granted).
REQ-012 In IDLE with req non-zero, the next cycle SHALL be GRANT with the arbitration winner granted (1-cycle latency, req edge to gnt).
REQ-013 In IDLE with req zero, the FSM SHALL stay in IDLE and all outputs SHALL be 0.
REQ-014 MODE 0 SHALL select the highest-index asserted req bit.
REQ-015 MODE 1 SHALL search from index last-1 downward, wrapping N-1 to 0, ending at last; last is the index of the most recent grant.
REQ-016 The grant SHALL be held while req[gnt_idx] stays high and the hold limit is not reached.
REQ-017 When req[gnt_idx] drops, the next cycle SHALL grant the winner among the remaining requests with no idle gap, or enter IDLE if none remain.
REQ-018 hold_cnt SHALL clear on every new grant and increment each GRANT cycle, saturating at MAX_HOLD-1.
REQ-019 When hold_cnt = MAX_HOLD-1 and any other req bit is high, the next cycle SHALL grant the winner among requests excluding the current channel.
REQ-020 When hold_cnt = MAX_HOLD-1 and no other request is pending, the grant SHALL continue and hold_cnt SHALL stay saturated.
REQ-021 Reissuing a grant to a different channel SHALL update last in the same edge as gnt.
REQ-022 Changes in req SHALL NOT alter gnt, gnt_idx or valid combinationally.
REQ-023 gnt SHALL be one-hot or zero on every cycle.
REQ-024 gnt_idx SHALL equal the index of the set gnt bit, or 0 when valid = 0.

Reset
REQ-025 rst_n low SHALL asynchronously force state IDLE, gnt = 0, gnt_idx = 0, valid = 0, hold_cnt = 0, last = 0.
REQ-026 Reset asserted mid-grant SHALL drop the grant immediately, without waiting for a clock edge.
REQ-027 After reset release, the first edge with req non-zero SHALL arbitrate using last = 0, so MODE 1 search order is N-1 down to 0.

Structure
REQ-028 A shared package prio_pkg SHALL hold the FSM state encoding (IDLE, GRANT) and a MODE_FIXED/MODE_RR constant pair.
REQ-029 A combinational sub-module prio_enc, parametrised by N, SHALL take a request vector plus a start index and return winner index and found flag.
REQ-030 prio_arbiter SHALL instantiate prio_enc once and implement masking, the FSM, hold_cnt and last around it.

Verification (N=4, MAX_HOLD=4 unless stated)
REQ-031 Reset, then req=0000 for 5 cycles -> gnt=0000, valid=0 throughout.
REQ-032 MODE 0, req=0110 -> one cycle later gnt=0100, gnt_idx=2, valid=1; drop req[2] -> next cycle gnt=0010, gnt_idx=1.
REQ-033 MODE 1, req=1111 held -> grants rotate 3,2,1,0,3, each lasting 4 cycles (hold limit).
REQ-034 MODE 0, req=1000 held 10 cycles with no other request -> gnt=1000 continuous; assert req[0] -> switch to gnt=0001 on the next edge.
REQ-035 Assert rst_n=0 mid-grant between edges -> gnt=0000 and valid=0 immediately; after release with req=0011 -> gnt=0010 one edge later.
REQ-036 A bench assertion SHALL check one-hot-or-zero gnt and gnt_idx/gnt consistency every cycle in all scenarios.
